// File: rtl/upcount_sequencer.sv
// Start/stop sequencer for a tick-gated up-counter with a programmable terminal
// value, one-shot or auto-reload operation, and a one-cycle completion pulse.
module upcount_sequencer #(
  parameter int WIDTH     = 4,
  parameter int LIMIT_RST = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LIM_INIT = WIDTH'(LIMIT_RST);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q,   lim_d;
  logic             per_q,   per_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // State and output registers; reset is asynchronous and takes effect mid-run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= CNT_ZERO;
      lim_q   <= LIM_INIT;
      per_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      per_q   <= per_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; stop always outranks start and tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    per_d   = per_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (stop) begin
          state_d = S_IDLE;
          // A finished run clears the count on stop; an aborted run keeps it.
          if (state_q == S_DONE) begin
            count_d = CNT_ZERO;
          end else begin
            count_d = count_q;
          end
        end else if (start) begin
          lim_d   = limit;
          per_d   = periodic;
          count_d = CNT_ZERO;
          state_d = S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q == lim_q) begin
            done_d = 1'b1;
            if (per_q) begin
              count_d = CNT_ZERO;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = CNT_ZERO;
      end
    endcase
    busy_d = (state_d == S_RUN);
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_upcount_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then random stimulus compared against an arithmetic reference model.
module tb_upcount_sequencer;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, periodic = 1'b0, tick = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] count;
  logic       busy, done;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  upcount_sequencer #(.WIDTH(4), .LIMIT_RST(15)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .limit(limit), .tick(tick), .count(count), .busy(busy), .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running, 2 finished.
  int m_mode, m_cnt, m_lim;
  bit m_per, m_done;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_lim = 15; m_per = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit sp, input bit p, input int l, input bit t);
    m_done = 1'b0;
    if (m_mode == 1) begin
      if (sp) m_mode = 0;
      else if (t) begin
        m_done = (m_cnt == m_lim);
        if (m_per) m_cnt = (m_cnt + 1) % (m_lim + 1);
        else begin
          m_cnt = (m_cnt + 1 > m_lim) ? m_lim : m_cnt + 1;
          if (m_done) m_mode = 2;
        end
      end
    end else if (sp) begin
      if (m_mode == 2) m_cnt = 0;
      m_mode = 0;
    end else if (s) begin
      m_lim = l; m_per = p; m_cnt = 0; m_mode = 1;
    end
  endtask

  function automatic logic [7:0] model_vec();
    logic [3:0] c;
    logic [1:0] st;
    c  = 4'(m_cnt);
    st = 2'(m_mode);
    return {c, (m_mode == 1), m_done, st};
  endfunction

  function automatic logic [7:0] pack(input logic [3:0] c, input logic b,
                                      input logic d, input logic [1:0] st);
    return {c, b, d, st};
  endfunction

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {count, busy, done, state};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b state=%0b, want count=%0d busy=%0b done=%0b state=%0b",
               name, act[7:4], act[3], act[2], act[1:0], exp[7:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic apply(input bit s, input bit sp, input bit p, input logic [3:0] l, input bit t);
    start = s; stop = sp; periodic = p; limit = l; tick = t;
    @(posedge clk);
    #1;
    model_edge(s, sp, p, int'(l), t);
  endtask

  typedef struct {
    bit s, sp, p;
    logic [3:0] l;
    bit t;
    logic [3:0] c;
    logic [1:0] st;
    bit b, d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit sp, bit p, logic [3:0] l, bit t,
                              logic [3:0] c, logic [1:0] st, bit b, bit d);
    vec_t v;
    v.s = s; v.sp = sp; v.p = p; v.l = l; v.t = t;
    v.c = c; v.st = st; v.b = b; v.d = d;
    return v;
  endfunction

  initial begin
    int n;
    bit t;
    // One-shot L=5, start ignored in RUN, aborts, stop-wins, limit=0.
    tbl.push_back(mk(1, 0, 0, 4'd5, 0, 4'd0, ST_RUN,  1, 0));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(0, 0, 0, 4'd0, 1, 4'(i), ST_RUN, 1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 4'd5, ST_DONE, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 4'd5, ST_DONE, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 4'd0, ST_IDLE, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'd3, 0, 4'd0, ST_IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd2, 1, 4'd0, ST_RUN,  1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 4'd1, ST_RUN,  1, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 1, 4'd2, ST_RUN,  1, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 1, 4'd2, ST_IDLE, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'd0, 0, 4'd0, ST_RUN,  1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, ST_RUN,  1, 0));
    tbl.push_back(mk(0, 0, 0, 4'd0, 1, 4'd0, ST_DONE, 0, 1));
    tbl.push_back(mk(0, 0, 0, 4'd0, 0, 4'd0, ST_DONE, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'd0, 0, 4'd0, ST_IDLE, 0, 0));

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack(4'd0, 1'b0, 1'b0, ST_IDLE));
    rst = 1'b1;

    foreach (tbl[i]) begin
      apply(tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].l, tbl[i].t);
      check($sformatf("tbl_%0d", i), pack(tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].st));
    end

    // Periodic L=3 with the limit input changed mid-run.
    apply(1, 0, 1, 4'd3, 0);
    check("per_start", pack(4'd0, 1'b1, 1'b0, ST_RUN));
    for (int i = 0; i < 9; i++) begin
      apply(0, 0, 0, 4'd1, 1);
      check($sformatf("per_%0d", i), pack(4'((i + 1) % 4), 1'b1, (i % 4) == 3, ST_RUN));
    end
    apply(0, 1, 0, 4'd0, 0);

    // Gated tick, L=4: done after the fifth tick.
    apply(1, 0, 0, 4'd4, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      t = (i % 2) == 0;
      apply(0, 0, 0, 4'd0, t);
      if (t) n++;
      if (n < 5)
        check($sformatf("gate_%0d", i), pack(4'(n), 1'b1, 1'b0, ST_RUN));
      else
        check($sformatf("gate_%0d", i), pack(4'd4, 1'b0, t && i == 8, ST_DONE));
    end

    // L=15 periodic from DONE: wraps 15 -> 0 with busy held.
    apply(1, 0, 1, 4'd15, 1);
    check("wrap_start", pack(4'd0, 1'b1, 1'b0, ST_RUN));
    for (int i = 0; i < 17; i++) begin
      apply(0, 0, 0, 4'd0, 1);
      check($sformatf("wrap_%0d", i), pack(4'((i + 1) % 16), 1'b1, i == 15, ST_RUN));
    end
    apply(0, 1, 0, 4'd0, 0);

    // Asynchronous reset mid-run at count 7.
    apply(1, 0, 0, 4'd10, 0);
    for (int i = 0; i < 7; i++) apply(0, 0, 0, 4'd0, 1);
    check("pre_reset", pack(4'd7, 1'b1, 1'b0, ST_RUN));
    #2 rst = 1'b0;
    #1 check("async_reset", pack(4'd0, 1'b0, 1'b0, ST_IDLE));
    #1 rst = 1'b1;
    model_reset();

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0);
      check($sformatf("rand_%0d", i), model_vec());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
